// File: rtl/tlb_miss_walker_if.sv
// Handshake bundle between the TLB, the page-table walker and the memory port.
// The master modport is the walker's view; slave is the surrounding system's view.
interface tlb_miss_walker_if #(
  parameter int PAGE_INDEX_BITS = 20,
  parameter int ASID_WIDTH      = 8
);
  localparam int ADDR_W = PAGE_INDEX_BITS + 12;

  logic                       miss_valid;
  logic                       miss_ready;
  logic [PAGE_INDEX_BITS-1:0] miss_vpage_idx;
  logic [ASID_WIDTH-1:0]      miss_asid;
  logic [PAGE_INDEX_BITS-1:0] ptbr;
  logic                       abort;

  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic [ADDR_W-1:0]          mem_req_addr;
  logic                       mem_resp_valid;
  logic [ADDR_W-1:0]          mem_resp_data;

  logic                       tlb_update_en;
  logic [PAGE_INDEX_BITS-1:0] tlb_vpage_idx;
  logic [ASID_WIDTH-1:0]      tlb_asid;
  logic [PAGE_INDEX_BITS-1:0] tlb_ppage_idx;
  logic                       tlb_present;
  logic                       tlb_exe_writable;
  logic                       tlb_supervisor;
  logic                       tlb_global;
  logic                       walk_fault;

  modport master (
    input  miss_valid, miss_vpage_idx, miss_asid, ptbr, abort,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr,
    output tlb_update_en, tlb_vpage_idx, tlb_asid, tlb_ppage_idx,
    output tlb_present, tlb_exe_writable, tlb_supervisor, tlb_global, walk_fault
  );

  modport slave (
    output miss_valid, miss_vpage_idx, miss_asid, ptbr, abort,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr,
    input  tlb_update_en, tlb_vpage_idx, tlb_asid, tlb_ppage_idx,
    input  tlb_present, tlb_exe_writable, tlb_supervisor, tlb_global, walk_fault
  );
endinterface

// File: rtl/tlb_miss_walker.sv
// Two-level hardware page-table walker: turns a TLB miss into PDE/PTE reads and
// a single TLB update pulse, or a fault pulse when the directory entry is absent.
module tlb_miss_walker #(
  parameter int PAGE_INDEX_BITS = 20,
  parameter int ASID_WIDTH      = 8
) (
  input logic                clk,
  input logic                reset,
  tlb_miss_walker_if.master  bus
);
  localparam int ADDR_W  = PAGE_INDEX_BITS + 12;
  localparam int L2_BITS = 10;

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, UPDATE, DRAIN
  } state_t;

  state_t                     state, state_next;
  logic [PAGE_INDEX_BITS-1:0] vpage_q, ptbr_q, pde_base_q, ppage_q;
  logic [ASID_WIDTH-1:0]      asid_q;
  logic [3:0]                 flags_q;
  logic                       update_q, fault_q;

  logic                       resp_take, pde_present;
  logic [ADDR_W-1:0]          l1_addr, l2_addr;
  logic                       resp_unused;

  // A response coinciding with abort is consumed but its contents are dropped.
  assign resp_take   = bus.mem_resp_valid && !bus.abort;
  assign pde_present = bus.mem_resp_data[0];
  assign resp_unused = ^bus.mem_resp_data[11:4];

  assign l1_addr = {ptbr_q, 12'h000} |
                   ADDR_W'({vpage_q[PAGE_INDEX_BITS-1:L2_BITS], 2'b00});
  assign l2_addr = {pde_base_q, vpage_q[L2_BITS-1:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.miss_valid) state_next = L1_REQ;
      L1_REQ:  if (bus.abort) state_next = IDLE;
               else if (bus.mem_req_ready) state_next = L1_WAIT;
      L1_WAIT: if (bus.mem_resp_valid) state_next = (resp_take && pde_present) ? L2_REQ : IDLE;
               else if (bus.abort) state_next = DRAIN;
      L2_REQ:  if (bus.abort) state_next = IDLE;
               else if (bus.mem_req_ready) state_next = L2_WAIT;
      L2_WAIT: if (bus.mem_resp_valid) state_next = resp_take ? UPDATE : IDLE;
               else if (bus.abort) state_next = DRAIN;
      UPDATE:  state_next = IDLE;
      DRAIN:   if (bus.mem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.miss_ready    = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    case (state)
      IDLE:    bus.miss_ready = 1'b1;
      L1_REQ:  begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = l1_addr;
      end
      L2_REQ:  begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = l2_addr;
      end
      default: ;
    endcase
  end

  // Walk context and fetched entry; update/fault pulses are registered off the response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpage_q    <= '0;
      asid_q     <= '0;
      ptbr_q     <= '0;
      pde_base_q <= '0;
      ppage_q    <= '0;
      flags_q    <= '0;
      update_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      update_q <= (state == L2_WAIT) && resp_take;
      fault_q  <= (state == L1_WAIT) && resp_take && !pde_present;
      if (state == IDLE && bus.miss_valid) begin
        vpage_q <= bus.miss_vpage_idx;
        asid_q  <= bus.miss_asid;
        ptbr_q  <= bus.ptbr;
      end
      if (state == L1_WAIT && resp_take)
        pde_base_q <= bus.mem_resp_data[ADDR_W-1:12];
      if (state == L2_WAIT && resp_take) begin
        ppage_q <= bus.mem_resp_data[ADDR_W-1:12];
        flags_q <= bus.mem_resp_data[3:0];
      end
    end
  end

  assign bus.tlb_update_en    = update_q;
  assign bus.walk_fault       = fault_q;
  assign bus.tlb_vpage_idx    = vpage_q;
  assign bus.tlb_asid         = asid_q;
  assign bus.tlb_ppage_idx    = ppage_q;
  assign bus.tlb_present      = flags_q[0];
  assign bus.tlb_exe_writable = flags_q[1];
  assign bus.tlb_supervisor   = flags_q[2];
  assign bus.tlb_global       = flags_q[3];
endmodule

// File: tb/tb_tlb_miss_walker.sv
// Scoreboard bench for tlb_miss_walker: a memory model answers walk reads and
// expected TLB updates/faults are queued at stimulus time and popped on output.
module tb_tlb_miss_walker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tlb_miss_walker_if bus ();
  tlb_miss_walker dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        fault;
    logic [19:0] vpage;
    logic [7:0]  asid;
    logic [19:0] ppage;
    logic [3:0]  flags;
    int          due;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          req_stall  = 0;
  int          resp_delay = 0;
  int          n_req      = 0;
  logic [31:0] mem_data [logic [31:0]];
  logic [31:0] exp_addr [$];
  exp_t        exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void expect_walk(input logic [19:0] vp, input logic [19:0] pt,
                                      input logic [31:0] pde, input logic [31:0] pte);
    logic [31:0] l1, l2;
    l1 = {pt, 12'h000} + {20'h0, vp[19:10], 2'b00};
    exp_addr.push_back(l1);
    mem_data[l1] = pde;
    if (pde[0]) begin
      l2 = {pde[31:12], 12'h000} + {20'h0, vp[9:0], 2'b00};
      exp_addr.push_back(l2);
      mem_data[l2] = pte;
    end
  endfunction

  function automatic void expect_update(input logic [19:0] vp, input logic [7:0] as,
                                        input logic [31:0] pte, input int due);
    exp_t e;
    e.fault = 1'b0; e.vpage = vp; e.asid = as;
    e.ppage = pte[31:12]; e.flags = pte[3:0]; e.due = due;
    exp_q.push_back(e);
  endfunction

  function automatic void expect_fault(input int due);
    exp_t e;
    e.fault = 1'b1; e.vpage = '0; e.asid = '0; e.ppage = '0; e.flags = '0; e.due = due;
    exp_q.push_back(e);
  endfunction

  // Memory model: optional ready stall, then one response resp_delay cycles after accept.
  initial begin : memory
    logic [31:0] a;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      bus.mem_req_ready  = 1'b0;
      if (bus.mem_req_valid && !reset) begin
        a = bus.mem_req_addr;
        for (int i = 0; i < req_stall; i++) begin
          @(negedge clk);
          chk("req_hold", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, a});
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        n_req++;
        if (exp_addr.size() != 0) chk("req_addr", a, exp_addr.pop_front());
        else                      chk("req_addr", a, 32'hFFFF_FFFF);
        repeat (resp_delay) @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = mem_data.exists(a) ? mem_data[a] : 32'h0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.tlb_update_en || bus.walk_fault)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {bus.tlb_update_en, bus.walk_fault}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {bus.tlb_update_en, bus.walk_fault}, e.fault ? 2'b01 : 2'b10);
          if (e.fault)
            chk("ready_after_fault", bus.miss_ready, 1'b1);
          else
            chk("tlb_entry", {bus.tlb_vpage_idx, bus.tlb_asid, bus.tlb_ppage_idx, bus.tlb_global,
                              bus.tlb_supervisor, bus.tlb_exe_writable, bus.tlb_present},
                             {e.vpage, e.asid, e.ppage, e.flags});
          if (e.due >= 0) chk("latency", cyc, e.due);
        end
      end
    end
  end

  task automatic send_miss(input logic [19:0] vp, input logic [7:0] as, input logic [19:0] pt,
                           input bit drop, output int c0);
    int n = 0;
    bus.miss_valid = 1'b1; bus.miss_vpage_idx = vp; bus.miss_asid = as; bus.ptbr = pt;
    while (!bus.miss_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("miss_accept_timeout", n, 0);
    c0 = cyc;
    @(negedge clk);
    if (drop) bus.miss_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || exp_addr.size() != 0 || !bus.miss_ready) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("walk_done", n < bound, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_reqs(input int target);
    int n = 0;
    while (n_req < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", n_req, target);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {bus.tlb_update_en, bus.walk_fault, bus.mem_req_valid, bus.tlb_vpage_idx,
              bus.tlb_asid, bus.tlb_ppage_idx, bus.tlb_present, bus.tlb_exe_writable,
              bus.tlb_supervisor, bus.tlb_global}, 64'h0);
    chk({tag, "_addr"}, bus.mem_req_addr, 32'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, c1;
    bus.miss_valid = 1'b0; bus.miss_vpage_idx = '0; bus.miss_asid = '0;
    bus.ptbr = '0; bus.abort = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.miss_ready, 1'b1);

    // Reference walk with fixed addresses and full-permission PTE.
    n_req = 0;
    exp_addr.push_back(32'h0001_0120);
    exp_addr.push_back(32'h0002_0D14);
    mem_data[32'h0001_0120] = 32'h0002_0001;
    mem_data[32'h0002_0D14] = 32'hABCD_E00F;
    send_miss(20'h12345, 8'h5A, 20'h00010, 1'b1, c0);
    expect_update(20'h12345, 8'h5A, 32'hABCD_E00F, c0 + 5);
    wait_done(100);
    chk("t1_req_count", n_req, 2);

    // Directory entry not present.
    n_req = 0;
    expect_walk(20'h2A3B4, 20'h00030, 32'h0002_0000, 32'h0);
    send_miss(20'h2A3B4, 8'h11, 20'h00030, 1'b1, c0);
    expect_fault(c0 + 3);
    wait_done(100);
    chk("t2_req_count", n_req, 1);

    // Stalled request and slow response; PTE with present=0 still written.
    req_stall = 5; resp_delay = 10;
    expect_walk(20'hFEDCB, 20'h00444, 32'h7654_3001, 32'h1234_500A);
    send_miss(20'hFEDCB, 8'hC3, 20'h00444, 1'b1, c0);
    expect_update(20'hFEDCB, 8'hC3, 32'h1234_500A, -1);
    wait_done(200);
    req_stall = 0; resp_delay = 0;

    // Abort while waiting on the PTE read; a new miss queued behind the drain.
    n_req = 0; resp_delay = 6;
    expect_walk(20'h0ABCD, 20'h00555, 32'h0006_6001, 32'h9999_9001);
    send_miss(20'h0ABCD, 8'h22, 20'h00555, 1'b1, c0);
    wait_reqs(2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    resp_delay = 0;
    chk("drain_busy", bus.miss_ready, 1'b0);
    expect_walk(20'h13579, 20'h00777, 32'h0008_8001, 32'h2468_A005);
    send_miss(20'h13579, 8'h33, 20'h00777, 1'b1, c0);
    expect_update(20'h13579, 8'h33, 32'h2468_A005, c0 + 5);
    wait_done(100);

    // miss_valid held across two back-to-back walks.
    expect_walk(20'h11111, 20'h00101, 32'h000A_0001, 32'h0B0B_0003);
    expect_walk(20'h22222, 20'h00202, 32'h000C_0001, 32'h0D0D_000C);
    send_miss(20'h11111, 8'h44, 20'h00101, 1'b0, c0);
    expect_update(20'h11111, 8'h44, 32'h0B0B_0003, c0 + 5);
    send_miss(20'h22222, 8'h55, 20'h00202, 1'b1, c1);
    expect_update(20'h22222, 8'h55, 32'h0D0D_000C, c1 + 5);
    chk("t5_accept_gap", c1 - c0, 6);
    wait_done(100);

    // Reset in the middle of the PTE read; the stale response must be ignored.
    n_req = 0; resp_delay = 3;
    expect_walk(20'h31415, 20'h00999, 32'h000E_E001, 32'h5555_500F);
    send_miss(20'h31415, 8'h66, 20'h00999, 1'b1, c0);
    wait_reqs(2);
    reset = 1'b1;
    #1;
    chk_outputs_zero("midwalk_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midwalk_reset", bus.miss_ready, 1'b1);
    resp_delay = 0;
    repeat (8) @(negedge clk);
    chk("no_event_after_reset", exp_q.size(), 0);
    expect_walk(20'h27182, 20'h00888, 32'h000F_F001, 32'h7777_7007);
    send_miss(20'h27182, 8'h77, 20'h00888, 1'b1, c0);
    expect_update(20'h27182, 8'h77, 32'h7777_7007, c0 + 5);
    wait_done(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
